// File: rtl/digit_entry.sv
// -----------------------------------------------------------------------------
// digit_entry
//
// Keypad/switch entry buffer for the 7-segment display path. A rising edge on
// i_enter latches i_sw into the slot under the cursor and advances it, a rising
// edge on i_back erases the previous slot, a rising edge on i_clr empties the
// buffer. Within one cycle clr beats back, which beats enter; the losers are
// dropped, not deferred.
//
// Build option:
//   DIGIT_ENTRY_WRAP_EN  defined   -> wrap mode: cursor runs 0..NUM_DIGITS-1,
//                                     enter always writes (oldest slot is
//                                     overwritten when full).
//                        undefined -> saturate mode (default): cursor runs
//                                     0..NUM_DIGITS, enter on a full buffer is
//                                     rejected.
//
// Ports:
//   i_clk      single clock, rising edge
//   i_rst      asynchronous, active-low reset
//   i_enter    write request (level, acted on at its rising edge)
//   i_back     erase request (level, acted on at its rising edge)
//   i_clr      clear request (level, acted on at its rising edge)
//   i_sw       digit value to write, sampled only at the accepting edge
//   o_digits   slot i at [i*DIGIT_W +: DIGIT_W], registered
//   o_vld      bit i set = slot i holds an entered digit, registered
//   o_cursor   next slot to write, registered
//   o_full     &o_vld
//   o_done     one-cycle pulse: an enter made o_full go 0->1
//   o_err      one-cycle pulse: a request was rejected
// -----------------------------------------------------------------------------
module digit_entry #(
    parameter int NUM_DIGITS = 4,
    parameter int DIGIT_W    = 4,
    parameter int CUR_W      = $clog2(NUM_DIGITS + 1)
) (
    input  logic                          i_clk,
    input  logic                          i_rst,
    input  logic                          i_enter,
    input  logic                          i_back,
    input  logic                          i_clr,
    input  logic [DIGIT_W-1:0]            i_sw,
    output logic [NUM_DIGITS*DIGIT_W-1:0] o_digits,
    output logic [NUM_DIGITS-1:0]         o_vld,
    output logic [CUR_W-1:0]              o_cursor,
    output logic                          o_full,
    output logic                          o_done,
    output logic                          o_err
);

`ifdef DIGIT_ENTRY_WRAP_EN
    localparam logic [CUR_W-1:0] LAST_IDX = CUR_W'(NUM_DIGITS - 1);
`endif

    // Edge-detect history; reset to 1 so a request held through reset release
    // is not seen as an edge.
    logic r_enter_q;
    logic r_back_q;
    logic r_clr_q;

    logic [NUM_DIGITS*DIGIT_W-1:0] r_digits;
    logic [NUM_DIGITS-1:0]         r_vld;
    logic [CUR_W-1:0]              r_cursor;
    logic                          r_done;
    logic                          r_err;

    logic                          w_enter_edge;
    logic                          w_back_edge;
    logic                          w_clr_edge;
    logic                          w_full;

    logic                          w_op_clear;
    logic                          w_op_erase;
    logic                          w_op_write;
    logic [CUR_W-1:0]              w_target;
    logic                          w_err_nxt;

    logic [NUM_DIGITS*DIGIT_W-1:0] w_digits_nxt;
    logic [NUM_DIGITS-1:0]         w_vld_nxt;
    logic [CUR_W-1:0]              w_cursor_nxt;
    logic                          w_done_nxt;

    assign w_enter_edge = i_enter & ~r_enter_q;
    assign w_back_edge  = i_back  & ~r_back_q;
    assign w_clr_edge   = i_clr   & ~r_clr_q;
    assign w_full       = &r_vld;

    // Decide which single operation (if any) this cycle performs and its target slot.
    always_comb begin
        w_op_clear = 1'b0;
        w_op_erase = 1'b0;
        w_op_write = 1'b0;
        w_target   = r_cursor;
        w_err_nxt  = 1'b0;
        if (w_clr_edge) begin
            w_op_clear = 1'b1;
        end else if (w_back_edge) begin
`ifdef DIGIT_ENTRY_WRAP_EN
            if (r_vld == {NUM_DIGITS{1'b0}}) begin
                w_err_nxt = 1'b1;
            end else begin
                w_op_erase = 1'b1;
                w_target   = (r_cursor == {CUR_W{1'b0}}) ? LAST_IDX
                                                         : (r_cursor - CUR_W'(1));
            end
`else
            if (r_cursor == {CUR_W{1'b0}}) begin
                w_err_nxt = 1'b1;
            end else begin
                w_op_erase = 1'b1;
                w_target   = r_cursor - CUR_W'(1);
            end
`endif
        end else if (w_enter_edge) begin
`ifdef DIGIT_ENTRY_WRAP_EN
            w_op_write = 1'b1;
`else
            if (w_full) begin
                w_err_nxt = 1'b1;
            end else begin
                w_op_write = 1'b1;
            end
`endif
        end else begin
            // Idle cycle: nothing to do, defaults hold the state.
            w_op_clear = 1'b0;
        end
    end

    // Build next buffer contents, cursor and done pulse from the chosen operation.
    always_comb begin
        w_digits_nxt = r_digits;
        w_vld_nxt    = r_vld;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            w_digits_nxt[i*DIGIT_W +: DIGIT_W] =
                w_op_clear                                  ? {DIGIT_W{1'b0}} :
                (w_op_write && (w_target == CUR_W'(i)))     ? i_sw :
                (w_op_erase && (w_target == CUR_W'(i)))     ? {DIGIT_W{1'b0}} :
                                                              r_digits[i*DIGIT_W +: DIGIT_W];
            w_vld_nxt[i] =
                w_op_clear                                  ? 1'b0 :
                (w_op_write && (w_target == CUR_W'(i)))     ? 1'b1 :
                (w_op_erase && (w_target == CUR_W'(i)))     ? 1'b0 :
                                                              r_vld[i];
        end

        if (w_op_clear) begin
            w_cursor_nxt = {CUR_W{1'b0}};
        end else if (w_op_erase) begin
            w_cursor_nxt = w_target;
        end else if (w_op_write) begin
`ifdef DIGIT_ENTRY_WRAP_EN
            w_cursor_nxt = (r_cursor == LAST_IDX) ? {CUR_W{1'b0}} : (r_cursor + CUR_W'(1));
`else
            w_cursor_nxt = r_cursor + CUR_W'(1);
`endif
        end else begin
            w_cursor_nxt = r_cursor;
        end

        // Only a write that turns a not-full buffer full counts as completion.
        w_done_nxt = w_op_write & ~w_full & (&w_vld_nxt);
    end

    // Edge-detect history registers.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_enter_q <= 1'b1;
            r_back_q  <= 1'b1;
            r_clr_q   <= 1'b1;
        end else begin
            r_enter_q <= i_enter;
            r_back_q  <= i_back;
            r_clr_q   <= i_clr;
        end
    end

    // Buffer state and status pulse registers.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_digits <= {(NUM_DIGITS*DIGIT_W){1'b0}};
            r_vld    <= {NUM_DIGITS{1'b0}};
            r_cursor <= {CUR_W{1'b0}};
            r_done   <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            r_digits <= w_digits_nxt;
            r_vld    <= w_vld_nxt;
            r_cursor <= w_cursor_nxt;
            r_done   <= w_done_nxt;
            r_err    <= w_err_nxt;
        end
    end

    assign o_digits = r_digits;
    assign o_vld    = r_vld;
    assign o_cursor = r_cursor;
    assign o_full   = w_full;
    assign o_done   = r_done;
    assign o_err    = r_err;

endmodule

// File: tb/tb_digit_entry.sv
// -----------------------------------------------------------------------------
// tb_digit_entry
//
// Self-checking bench for digit_entry (NUM_DIGITS=4, DIGIT_W=4). A behavioural
// model (a digit list in saturate mode, a ring of slots in wrap mode) is
// stepped on every clock edge and compared with the DUT on every falling edge.
// Directed scenarios add literal expectations; a randomized phase follows.
// -----------------------------------------------------------------------------
module tb_digit_entry;
    localparam int N  = 4;
    localparam int W  = 4;
    localparam int CW = $clog2(N + 1);

    logic          clk   = 1'b0;
    logic          rst   = 1'b0;
    logic          enter = 1'b0;
    logic          back  = 1'b0;
    logic          clr   = 1'b0;
    logic [W-1:0]  sw    = '0;
    logic [N*W-1:0] o_digits;
    logic [N-1:0]  o_vld;
    logic [CW-1:0] o_cursor;
    logic          o_full;
    logic          o_done;
    logic          o_err;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    digit_entry #(.NUM_DIGITS(N), .DIGIT_W(W)) dut (
        .i_clk    (clk),
        .i_rst    (rst),
        .i_enter  (enter),
        .i_back   (back),
        .i_clr    (clr),
        .i_sw     (sw),
        .o_digits (o_digits),
        .o_vld    (o_vld),
        .o_cursor (o_cursor),
        .o_full   (o_full),
        .o_done   (o_done),
        .o_err    (o_err)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
`ifdef DIGIT_ENTRY_WRAP_EN
    int md[N];
    bit mv[N];
    int mc;
`else
    int mq[$];
`endif
    bit m_done, m_err;
    bit pe, pb, pc;

    function void model_reset();
`ifdef DIGIT_ENTRY_WRAP_EN
        for (int i = 0; i < N; i++) begin md[i] = 0; mv[i] = 1'b0; end
        mc = 0;
`else
        mq.delete();
`endif
        m_done = 1'b0; m_err = 1'b0;
        pe = 1'b1; pb = 1'b1; pc = 1'b1;
    endfunction

    function bit exp_full();
`ifdef DIGIT_ENTRY_WRAP_EN
        bit f;
        f = 1'b1;
        for (int i = 0; i < N; i++) f = f & mv[i];
        return f;
`else
        return mq.size() == N;
`endif
    endfunction

    function bit any_valid();
`ifdef DIGIT_ENTRY_WRAP_EN
        bit a;
        a = 1'b0;
        for (int i = 0; i < N; i++) a = a | mv[i];
        return a;
`else
        return mq.size() != 0;
`endif
    endfunction

    function void model_step(bit e_in, bit b_in, bit c_in, int s);
        bit e, b, c, was_full;
        e = e_in & ~pe;
        b = b_in & ~pb;
        c = c_in & ~pc;
        m_done = 1'b0;
        m_err  = 1'b0;
        was_full = exp_full();
        if (c) begin
`ifdef DIGIT_ENTRY_WRAP_EN
            for (int i = 0; i < N; i++) begin md[i] = 0; mv[i] = 1'b0; end
            mc = 0;
`else
            mq.delete();
`endif
        end else if (b) begin
            if (!any_valid()) m_err = 1'b1;
            else begin
`ifdef DIGIT_ENTRY_WRAP_EN
                mc = (mc + N - 1) % N;
                md[mc] = 0;
                mv[mc] = 1'b0;
`else
                void'(mq.pop_back());
`endif
            end
        end else if (e) begin
`ifdef DIGIT_ENTRY_WRAP_EN
            md[mc] = s;
            mv[mc] = 1'b1;
            mc = (mc + 1) % N;
            m_done = !was_full && exp_full();
`else
            if (was_full) m_err = 1'b1;
            else begin
                mq.push_back(s);
                m_done = exp_full();
            end
`endif
        end
        pe = e_in; pb = b_in; pc = c_in;
    endfunction

    function logic [N*W-1:0] exp_digits();
        logic [N*W-1:0] r;
        r = '0;
`ifdef DIGIT_ENTRY_WRAP_EN
        for (int i = 0; i < N; i++) r[i*W +: W] = W'(md[i]);
`else
        for (int i = 0; i < mq.size(); i++) r[i*W +: W] = W'(mq[i]);
`endif
        return r;
    endfunction

    function logic [N-1:0] exp_vld();
        logic [N-1:0] r;
        r = '0;
`ifdef DIGIT_ENTRY_WRAP_EN
        for (int i = 0; i < N; i++) r[i] = mv[i];
`else
        for (int i = 0; i < mq.size(); i++) r[i] = 1'b1;
`endif
        return r;
    endfunction

    function logic [CW-1:0] exp_cursor();
`ifdef DIGIT_ENTRY_WRAP_EN
        return CW'(mc);
`else
        return CW'(mq.size());
`endif
    endfunction

    // model stepping: async reset, otherwise one step per rising clock edge
    initial begin
        model_reset();
        forever begin
            @(posedge clk or negedge rst);
            if (!rst) model_reset();
            else model_step(enter, back, clr, int'(sw));
        end
    end

    // compare process: outputs are all register-derived, so check mid-cycle
    initial begin
        forever begin
            @(negedge clk);
            chk("digits", o_digits, exp_digits());
            chk("vld",    o_vld,    exp_vld());
            chk("cursor", o_cursor, exp_cursor());
            chk("full",   o_full,   exp_full());
            chk("done",   o_done,   m_done);
            chk("err",    o_err,    m_err);
        end
    end

    // one request cycle; reports done/err seen one cycle after the request
    task automatic req(input bit e, input bit b, input bit c, input logic [W-1:0] s,
                       output bit d_seen, output bit e_seen);
        @(negedge clk);
        enter = e; back = b; clr = c; sw = s;
        @(negedge clk);
        d_seen = o_done;
        e_seen = o_err;
        enter = 1'b0; back = 1'b0; clr = 1'b0;
        sw = W'($urandom);
    endtask

    initial begin
        bit d, e;
        int dcnt, ecnt;
        logic [W-1:0] vals [4];
        vals[0] = 4'h3; vals[1] = 4'h7; vals[2] = 4'hA; vals[3] = 4'hF;

        // reset state
        rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_digits", o_digits, 16'h0000);
        chk("rst_vld",    o_vld,    4'h0);
        chk("rst_cursor", o_cursor, 3'd0);
        chk("rst_done",   o_done,   1'b0);
        chk("rst_err",    o_err,    1'b0);
        rst = 1'b1;

        // four enters fill the buffer
        dcnt = 0; ecnt = 0;
        for (int i = 0; i < 4; i++) begin
            req(1'b1, 1'b0, 1'b0, vals[i], d, e);
            dcnt += int'(d); ecnt += int'(e);
        end
        chk("fill_digits", o_digits, 16'hFA73);
        chk("fill_vld",    o_vld,    4'hF);
`ifdef DIGIT_ENTRY_WRAP_EN
        chk("fill_cursor", o_cursor, 3'd0);
`else
        chk("fill_cursor", o_cursor, 3'd4);
`endif
        chk("fill_done_cnt", 64'(dcnt), 64'd1);
        chk("fill_err_cnt",  64'(ecnt), 64'd0);

        // fifth enter on a full buffer
        req(1'b1, 1'b0, 1'b0, 4'h1, d, e);
`ifdef DIGIT_ENTRY_WRAP_EN
        chk("over_err",    e, 1'b0);
        chk("over_digits", o_digits, 16'hFA71);
        chk("over_cursor", o_cursor, 3'd1);
`else
        chk("over_err",    e, 1'b1);
        chk("over_digits", o_digits, 16'hFA73);
        chk("over_cursor", o_cursor, 3'd4);
`endif
        @(negedge clk);
        chk("over_err_1cyc", o_err, 1'b0);

        // clear, three enters, back twice
        req(1'b0, 1'b0, 1'b1, 4'h0, d, e);
        chk("clr_err", e, 1'b0);
        req(1'b1, 1'b0, 1'b0, 4'h1, d, e);
        req(1'b1, 1'b0, 1'b0, 4'h2, d, e);
        req(1'b1, 1'b0, 1'b0, 4'h3, d, e);
        req(1'b0, 1'b1, 1'b0, 4'h0, d, e);
        req(1'b0, 1'b1, 1'b0, 4'h0, d, e);
        chk("back_vld",    o_vld,    4'h1);
        chk("back_digits", o_digits, 16'h0001);
        chk("back_cursor", o_cursor, 3'd1);
        req(1'b0, 1'b1, 1'b0, 4'h0, d, e);
        chk("back3_err", e, 1'b0);
        req(1'b0, 1'b1, 1'b0, 4'h0, d, e);
        chk("back4_err", e, 1'b1);
        chk("back4_vld", o_vld, 4'h0);

        // simultaneous clr/back/enter with two digits held
        req(1'b1, 1'b0, 1'b0, 4'h4, d, e);
        req(1'b1, 1'b0, 1'b0, 4'h5, d, e);
        req(1'b1, 1'b1, 1'b1, 4'h9, d, e);
        chk("prio_err",    e, 1'b0);
        chk("prio_vld",    o_vld,    4'h0);
        chk("prio_cursor", o_cursor, 3'd0);
        chk("prio_digits", o_digits, 16'h0000);

        // held enter writes once
        @(negedge clk);
        enter = 1'b1; sw = 4'h9;
        repeat (20) @(negedge clk);
        enter = 1'b0;
        chk("hold_cursor", o_cursor, 3'd1);
        chk("hold_digits", o_digits, 16'h0009);

        // enter held across reset release is not an edge
        @(negedge clk);
        enter = 1'b1; sw = 4'h6; rst = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (5) @(negedge clk);
        chk("hold_rst_cursor", o_cursor, 3'd0);
        chk("hold_rst_vld",    o_vld,    4'h0);
        enter = 1'b0;
        req(1'b1, 1'b0, 1'b0, 4'h6, d, e);
        chk("after_rst_cursor", o_cursor, 3'd1);
        chk("after_rst_digits", o_digits, 16'h0006);

        // asynchronous reset mid-operation
        req(1'b1, 1'b0, 1'b0, 4'h2, d, e);
        @(posedge clk);
        #2 rst = 1'b0;
        #1;
        chk("async_digits", o_digits, 16'h0000);
        chk("async_vld",    o_vld,    4'h0);
        chk("async_cursor", o_cursor, 3'd0);
        chk("async_full",   o_full,   1'b0);
        @(negedge clk);
        rst = 1'b1;
        req(1'b1, 1'b0, 1'b0, 4'h8, d, e);
        chk("async_next_digits", o_digits, 16'h0008);
        chk("async_next_cursor", o_cursor, 3'd1);

        // randomized phase, model compares every cycle
        for (int k = 0; k < 800; k++) begin
            @(negedge clk);
            rst   = ($urandom_range(0, 199) != 0);
            enter = ($urandom_range(0, 1) == 0);
            back  = ($urandom_range(0, 3) == 0);
            clr   = ($urandom_range(0, 19) == 0);
            sw    = W'($urandom);
        end
        @(negedge clk);
        rst = 1'b1; enter = 1'b0; back = 1'b0; clr = 1'b0;
        repeat (2) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
